// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and the per-edge operation encoding for gray_counter.
// Functions work on a fixed 32-bit container; narrower callers zero-extend.
package gray_pkg;

    localparam int GRAY_FN_WIDTH = 32;

    typedef enum logic [1:0] {
        OP_HOLD  = 2'd0,
        OP_LOAD  = 2'd1,
        OP_COUNT = 2'd2
    } op_t;

    function automatic logic [GRAY_FN_WIDTH-1:0] bin2gray(input logic [GRAY_FN_WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Prefix XOR from the MSB down: each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [GRAY_FN_WIDTH-1:0] gray2bin(input logic [GRAY_FN_WIDTH-1:0] g);
        logic [GRAY_FN_WIDTH-1:0] b;
        b[GRAY_FN_WIDTH-1] = g[GRAY_FN_WIDTH-1];
        for (int i = GRAY_FN_WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/bin2gray_enc.sv
// Combinational binary-to-Gray encoder; the MSB passes through, every other bit
// is the XOR of itself and its upper neighbour.
module bin2gray_enc #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);

    assign gray[WIDTH-1] = bin[WIDTH-1];

    generate
        for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_xor
            assign gray[gi] = bin[gi] ^ bin[gi+1];
        end
    endgenerate

endmodule

// File: rtl/gray_counter.sv
// Up/down binary counter with registered Gray output, parallel load,
// combinational terminal count and a registered wrap-around pulse.
module gray_counter
    import gray_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_bin,
    output logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    logic [WIDTH-1:0] bin_reg;
    logic [WIDTH-1:0] gray_reg;
    logic             wrap_reg;

    logic [WIDTH-1:0] bin_next;
    logic [WIDTH-1:0] gray_next;
    logic             wrap_next;
    op_t              op;

    always_comb begin
        op        = OP_HOLD;
        bin_next  = bin_reg;
        wrap_next = 1'b0;
        if (load) begin
            op = OP_LOAD;
        end else if (en) begin
            op = OP_COUNT;
        end
        case (op)
            OP_LOAD: begin
                bin_next = load_bin;
            end
            OP_COUNT: begin
                if (up) begin
                    bin_next  = bin_reg + ONE;
                    wrap_next = (bin_reg == MAX);
                end else begin
                    bin_next  = bin_reg - ONE;
                    wrap_next = (bin_reg == ZERO);
                end
            end
            default: begin
                bin_next = bin_reg;
            end
        endcase
    end

    // Encoding bin_next lets gray be registered on the same edge as bin, so they never skew.
    bin2gray_enc #(
        .WIDTH(WIDTH)
    ) u_enc (
        .bin  (bin_next),
        .gray (gray_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            bin_reg  <= ZERO;
            gray_reg <= ZERO;
            wrap_reg <= 1'b0;
        end else begin
            bin_reg  <= bin_next;
            gray_reg <= gray_next;
            wrap_reg <= wrap_next;
        end
    end

    assign bin  = bin_reg;
    assign gray = gray_reg;
    assign wrap = wrap_reg;
    assign tc   = up ? (bin_reg == MAX) : (bin_reg == ZERO);

endmodule

// File: tb/tb_gray_counter.sv
// Scoreboard bench for gray_counter: the driver pushes expected state from an
// integer-arithmetic model; a monitor pops and compares once per clock.
module tb_gray_counter;
    import gray_pkg::*;

    localparam int W    = 4;
    localparam int MODN = 1 << W;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en = 1'b0;
    logic         up = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_bin = '0;
    logic [W-1:0] bin;
    logic [W-1:0] gray;
    logic         tc;
    logic         wrap;

    gray_counter #(
        .WIDTH(W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_bin (load_bin),
        .bin      (bin),
        .gray     (gray),
        .tc       (tc),
        .wrap     (wrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        int  exp_bin;
        int  exp_gray;
        bit  exp_wrap;
        bit  exp_tc;
        bit  is_step;
        bit  is_reset;
    } exp_t;

    exp_t sb[$];
    int   applied    = 0;
    int   miscompares = 0;
    int   m_bin      = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        if (act !== req) begin
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
            miscompares++;
        end
    endtask

    // Model: counter is an integer taken modulo 2**W; Gray is n xor n/2.
    task automatic drive(input bit r, input bit e, input bit u, input bit l, input int lb);
        exp_t x;
        bit   w;
        @(negedge clk);
        rst      = r;
        en       = e;
        up       = u;
        load     = l;
        load_bin = W'(lb);
        w = 1'b0;
        if (r) begin
            m_bin = 0;
        end else if (l) begin
            m_bin = lb % MODN;
        end else if (e) begin
            if (u) begin
                w     = (m_bin == MODN - 1);
                m_bin = (m_bin + 1) % MODN;
            end else begin
                w     = (m_bin == 0);
                m_bin = (m_bin + MODN - 1) % MODN;
            end
        end
        x.exp_bin  = m_bin;
        x.exp_gray = m_bin ^ (m_bin / 2);
        x.exp_wrap = w;
        x.exp_tc   = u ? (m_bin == MODN - 1) : (m_bin == 0);
        x.is_step  = !r && !l && e;
        x.is_reset = r;
        sb.push_back(x);
        applied++;
        $display("vec %0d: rst=%0b load=%0b lb=%0d en=%0b up=%0b -> exp bin=%0d gray=%0d wrap=%0b tc=%0b",
                 applied, r, l, lb, e, u, x.exp_bin, x.exp_gray, x.exp_wrap, x.exp_tc);
    endtask

    // Monitor: the DUT presents a new state every clock; compare just after the edge.
    initial begin
        exp_t         x;
        logic [W-1:0] prev_gray;
        bit           have_prev;
        have_prev = 1'b0;
        prev_gray = '0;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                chk("bin", 32'(bin), x.exp_bin);
                chk("gray", 32'(gray), x.exp_gray);
                chk("wrap", 32'(wrap), 32'(x.exp_wrap));
                chk("tc", 32'(tc), 32'(x.exp_tc));
                chk("gray2bin", gray2bin(32'(gray)), 32'(bin));
                if (x.is_step && have_prev) begin
                    chk("onebit", $countones(prev_gray ^ gray), 1);
                end
                prev_gray = gray;
                have_prev = 1'b1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time bound, got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int r;
        // Reset, full up cycle including wrap 15->0, then one more step.
        drive(1, 1, 1, 0, 0);
        for (int i = 0; i < 17; i++) drive(0, 1, 1, 0, 0);
        // Reset, then count down through 0->15 wrap and the reversed sequence.
        drive(1, 0, 0, 0, 0);
        for (int i = 0; i < 18; i++) drive(0, 1, 0, 0, 0);
        // Load beats enable.
        drive(0, 1, 1, 1, 10);
        drive(0, 0, 1, 0, 0);
        // Count to 6, hold three cycles, then reverse direction.
        drive(1, 0, 1, 0, 0);
        for (int i = 0; i < 6; i++) drive(0, 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) drive(0, 0, 1, 0, 0);
        drive(0, 1, 0, 0, 0);
        drive(0, 1, 1, 0, 0);
        // Load 13, then reset together with en and load.
        drive(0, 0, 1, 1, 13);
        drive(1, 1, 1, 1, 7);
        // Load MAX and wrap upward; load 0 and wrap downward.
        drive(0, 0, 1, 1, 15);
        drive(0, 1, 1, 0, 0);
        drive(0, 0, 0, 1, 0);
        drive(0, 1, 0, 0, 0);
        // Randomized phase.
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 99));
            drive(r < 3, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  r >= 3 && r < 10, int'($urandom_range(0, MODN - 1)));
        end
        drive(0, 0, 1, 0, 0);
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
            miscompares++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule

// File: doc/gray_counter.md
Name: gray_counter

Overview:
- Parameterised up/down counter that produces Gray-coded output. Binary and Gray states are held in registers.
- It is the producer of the Gray sequences that the team's Gray-to-binary decoder consumes, e.g. pointer generation for clock-domain-crossing FIFOs and position-encoder emulation.
- Supports parallel load of a binary value and flags terminal count and wrap-around.

Parameters:
- WIDTH, 4, counter width in bits (WIDTH >= 2).
- MAX, derived as 2**WIDTH-1 (localparam, not overridable), all-ones terminal value.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  count enable; advances one step per cycle while high.
- up  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  parallel load strobe.
- load_bin  input  WIDTH  binary value captured when load=1.
- bin  output  WIDTH  registered binary count.
- gray  output  WIDTH  registered Gray code of bin.
- tc  output  1  combinational terminal count.
- wrap  output  1  registered one-cycle pulse after a wrap-around step.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high, sampled only on the rising edge of clk.
- Priority per edge: rst > load > en > hold.
- Reset values: bin=0, gray=0, wrap=0. tc then equals (up==0), since bin=0.
- Load: bin<=load_bin, gray<=load_bin^(load_bin>>1), wrap<=0.
  - Ignores en and up in the same cycle.
  - Latency is 1 cycle; the value is visible the cycle after load.
- Count (en=1, load=0): bin_next = bin+1 when up=1, bin-1 when up=0, modulo 2**WIDTH.
  - gray<=bin2gray(bin_next) on the same edge, so there is no lag between bin and gray.
- wrap: asserted for exactly one cycle after a counting step that goes from MAX to 0 (up) or from 0 to MAX (down). Deasserted on every other edge.
- Hold (en=0, load=0): bin and gray unchanged, wrap<=0.
- tc = (up && bin==MAX) || (!up && bin==0), combinational from current state and up.
- Invariant checked every cycle: gray == bin ^ (bin>>1).
- Invariant: any counting step changes exactly one bit of gray. This includes wrap steps, e.g. 4'b1000 <-> 4'b0000.
- A direction change mid-count takes effect on the next enabled edge with no bubble.
- Reset asserted mid-count, or together with load/en, forces the reset values on that edge.
- Width rule: shift is logical (MSB of gray equals MSB of bin). No sign handling.

Decomposition:
- Shared package gray_pkg:
  - function bin2gray(bin) = bin ^ (bin>>1).
  - function gray2bin (prefix XOR from the MSB down) for benches and scoreboards.
- One natural sub-module: bin2gray_enc, a WIDTH-parameterised combinational encoder. It is instantiated once on bin_next, mirroring the existing decoder.
- Counter, load mux and wrap detection stay in gray_counter.

Test Plan:
- Reset, then en=1, up=1 for 16 cycles, WIDTH=4 -> gray follows 0,1,3,2,6,7,5,4,12,13,15,14,10,11,9,8; bin 0..15; one-bit change per step.
- Continue one more enabled cycle -> bin 15->0, gray 8->0, wrap=1 for exactly one cycle. tc=1 while bin=15 and up=1.
- After reset, up=0, en=1 -> bin 0->15, gray 0->8, wrap pulse. Continue down -> gray sequence reversed (8,9,11,10,...).
- load=1, load_bin=4'd10, en=1 in the same cycle -> next cycle bin=10, gray=4'b1111, wrap=0. Load wins over en.
- Count to bin=6 (gray 5), then en=0 for 3 cycles -> outputs held. Toggle up mid-run -> next enabled step goes 6->5 (gray 5->7).
- rst=1 asserted with en=1 at bin=13 -> next edge bin=0, gray=0, wrap=0. gray2bin(gray)==bin verified every cycle.
